// File: rtl/mem_ctrl_if.sv
// Bus bundle between the two cache ports, the controller and the byte-wide RAM.
// slave is the controller's view; master is the requester/RAM side.
interface mem_ctrl_if;
    logic [3:0]  rw_flag_i;
    logic [63:0] addr_i;
    logic [63:0] w_data_i;
    logic [7:0]  w_mask_i;
    logic [63:0] r_data_o;
    logic [1:0]  busy_o;
    logic [1:0]  done_o;
    logic [31:0] ram_addr_o;
    logic        ram_re_o;
    logic        ram_we_o;
    logic [7:0]  ram_w_data_o;
    logic [7:0]  ram_r_data_i;

    modport slave (
        input  rw_flag_i, addr_i, w_data_i, w_mask_i, ram_r_data_i,
        output r_data_o, busy_o, done_o, ram_addr_o, ram_re_o, ram_we_o, ram_w_data_o
    );

    modport master (
        output rw_flag_i, addr_i, w_data_i, w_mask_i, ram_r_data_i,
        input  r_data_o, busy_o, done_o, ram_addr_o, ram_re_o, ram_we_o, ram_w_data_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// Two-port word controller in front of a byte-wide RAM: port 0 (dcache) has fixed
// priority; reads are pipelined against RD_LATENCY, writes skip disabled bytes.
module mem_ctrl #(
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    port_q, port_d;
    logic [31:0]             base_q, base_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              mask_q, mask_d;
    logic [2:0]              icnt_q, icnt_d;
    logic [1:0]              rcnt_q, rcnt_d;
    logic [31:0]             rbuf_q, rbuf_d;
    logic [1:0][31:0]        rdata_q, rdata_d;
    logic [RD_LATENCY-1:0]   vld_pipe_q, vld_pipe_d;

    logic        re_s, we_s;
    logic [31:0] raddr_s;
    logic [7:0]  wbyte_s;
    logic        v0, v1, sel, sel_rd;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_mask;
    logic [1:0]  wk;
    logic        ret;

    // 2'b11 falls out as "not a request" because only 01/10 are recognised
    assign v0        = (bus.rw_flag_i[1:0] == 2'b01) || (bus.rw_flag_i[1:0] == 2'b10);
    assign v1        = (bus.rw_flag_i[3:2] == 2'b01) || (bus.rw_flag_i[3:2] == 2'b10);
    assign sel       = !v0;
    assign sel_rd    = sel ? (bus.rw_flag_i[3:2] == 2'b01) : (bus.rw_flag_i[1:0] == 2'b01);
    assign sel_addr  = sel ? bus.addr_i[63:32]   : bus.addr_i[31:0];
    assign sel_wdata = sel ? bus.w_data_i[63:32] : bus.w_data_i[31:0];
    assign sel_mask  = sel ? bus.w_mask_i[7:4]   : bus.w_mask_i[3:0];

    // A returning byte only counts while still in READ, so bytes that land
    // after a reset abort are dropped (the pipe is cleared as well).
    assign ret = vld_pipe_q[RD_LATENCY-1] && (state_q == READ);

    always_comb begin
        wk = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (mask_q[i]) wk = 2'(i);
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        icnt_d  = icnt_q;
        rcnt_d  = rcnt_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        re_s    = 1'b0;
        we_s    = 1'b0;
        raddr_s = 32'h0;
        wbyte_s = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (v0 || v1) begin
                    port_d  = sel;
                    base_d  = sel_addr & ~32'h3;
                    wdata_d = sel_wdata;
                    mask_d  = sel_mask;
                    icnt_d  = 3'd0;
                    rcnt_d  = 2'd0;
                    if (sel_rd)              state_d = READ;
                    else if (sel_mask == 4'b0) state_d = DONE;
                    else                     state_d = WRITE;
                end
            end
            READ: begin
                if (icnt_q < 3'd4) begin
                    re_s    = 1'b1;
                    raddr_s = base_q + 32'(icnt_q);
                    icnt_d  = icnt_q + 3'd1;
                end
                if (ret) begin
                    rbuf_d[{rcnt_q, 3'b000} +: 8] = bus.ram_r_data_i;
                    rcnt_d = rcnt_q + 2'd1;
                    if (rcnt_q == 2'd3) begin
                        // publish the whole word at once so r_data_o never shows a partial read
                        rdata_d[port_q] = {bus.ram_r_data_i, rbuf_q[23:0]};
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                we_s    = 1'b1;
                raddr_s = base_q + 32'(wk);
                wbyte_s = wdata_q[{wk, 3'b000} +: 8];
                mask_d  = mask_q & ~(4'b0001 << wk);
                if (mask_d == 4'b0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_pipe_d    = vld_pipe_q << 1;
        vld_pipe_d[0] = re_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            port_q     <= 1'b0;
            base_q     <= 32'h0;
            wdata_q    <= 32'h0;
            mask_q     <= 4'h0;
            icnt_q     <= 3'd0;
            rcnt_q     <= 2'd0;
            rbuf_q     <= 32'h0;
            rdata_q    <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            icnt_q     <= icnt_d;
            rcnt_q     <= rcnt_d;
            rbuf_q     <= rbuf_d;
            rdata_q    <= rdata_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign bus.r_data_o     = rdata_q;
    assign bus.busy_o       = (state_q != IDLE) ? 2'b11 : 2'b00;
    assign bus.done_o       = (state_q == DONE) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.ram_re_o     = re_s;
    assign bus.ram_we_o     = we_s;
    assign bus.ram_addr_o   = raddr_s;
    assign bus.ram_w_data_o = wbyte_s;
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, giving the cycles from ram_re_o to valid ram_r_data_i (legal range 1..3).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port rw_flag_i, input, 4 bits: per-port request flags; [3:2] is port 1 (instruction cache), [1:0] is port 0 (data cache); 2'b01 read, 2'b10 write, 2'b00 idle.
REQ-005 SHALL have port addr_i, input, 64 bits: per-port byte address; [63:32] port 1, [31:0] port 0.
REQ-006 SHALL have port w_data_i, input, 64 bits: per-port write word, split as addr_i.
REQ-007 SHALL have port w_mask_i, input, 8 bits: per-port byte-enable mask; [7:4] port 1, [3:0] port 0; bit k enables byte k.
REQ-008 SHALL have port r_data_o, output, 64 bits: per-port read word, split as addr_i.
REQ-009 SHALL have port busy_o, output, 2 bits: per-port busy; bit 1 port 1, bit 0 port 0.
REQ-010 SHALL have port done_o, output, 2 bits: per-port completion pulse.
REQ-011 SHALL have port ram_addr_o, output, 32 bits: byte address to the external RAM.
REQ-012 SHALL have port ram_re_o, output, 1 bit: byte read strobe.
REQ-013 SHALL have port ram_we_o, output, 1 bit: byte write strobe.
REQ-014 SHALL have port ram_w_data_o, output, 8 bits: write byte.
REQ-015 SHALL have port ram_r_data_i, input, 8 bits: read byte, valid RD_LATENCY cycles after its ram_re_o cycle.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE and DONE.
REQ-017 SHALL, in IDLE, sample rw_flag_i; when both ports request in the same cycle, port 0 SHALL be accepted (fixed priority).
REQ-018 SHALL latch the accepted port's address, data and mask at acceptance; base address = addr with bits [1:0] forced to 0.
REQ-019 SHALL ignore rw_flag value 2'b11 as if idle.
REQ-020 SHALL drive both busy_o bits high in every non-IDLE state; in IDLE both SHALL be 0.
REQ-021 SHALL, in READ, issue ram_re_o on 4 consecutive cycles with ram_addr_o = base+0, +1, +2, +3.
REQ-022 SHALL capture each returned byte k into bits [8k+7:8k] of the served port's r_data_o (little-endian).
REQ-023 SHALL use issue and return counters so that issuing is pipelined against RD_LATENCY.
REQ-024 SHALL enter DONE the cycle after the 4th byte is valid; with acceptance in cycle 0, DONE is in cycle 5+RD_LATENCY.
REQ-025 SHALL, in WRITE, issue one ram_we_o cycle per set mask bit, in ascending k, with ram_addr_o = base+k and ram_w_data_o = w_data[8k+7:8k]; clear bits SHALL cost no cycle.
REQ-026 SHALL enter DONE the cycle after the last write; a write with mask 0 SHALL enter DONE in cycle 1 with no ram_we_o.
REQ-027 SHALL, in DONE, pulse done_o for the served port only for exactly one cycle, then return to IDLE; the requester drops its flag during DONE.
REQ-028 SHALL hold r_data_o of a port stable from its DONE until that port's next read completes; writes SHALL not alter r_data_o.
REQ-029 SHALL never assert ram_re_o and ram_we_o together; when neither is asserted, ram_addr_o and ram_w_data_o SHALL be 0.

Reset
REQ-030 SHALL, while rst is high, force state IDLE and all outputs (r_data_o, busy_o, done_o, ram_*) to 0 immediately, regardless of clk.
REQ-031 SHALL abort any in-flight transaction on reset without a done pulse; late-returning RAM bytes SHALL be ignored.

Verification
REQ-032 SHALL cover: rst=1 mid-idle -> all outputs 0 with no clock edge.
REQ-033 SHALL cover: port 0 read of 0x100, RAM bytes 0x11/0x22/0x33/0x44 at 0x100..0x103, RD_LATENCY=1 -> ram_re_o cycles 1-4, done_o[0] in cycle 6, r_data_o[31:0]=0x44332211.
REQ-034 SHALL cover: port 1 write of 0x200, data 0xAABBCCDD, mask 4'b0101 -> writes (0x200, 0xDD) in cycle 1 and (0x202, 0xBB) in cycle 2, done_o[1] in cycle 3.
REQ-035 SHALL cover: port 0 write and port 1 read requested in the same cycle -> port 0 completes first; port 1 is accepted in the following IDLE and gets its done_o[1] later; no overlapping strobes.
REQ-036 SHALL cover: rst pulsed during the 3rd read byte -> strobes drop at once, no done_o; a read after release completes with correct data.
REQ-037 SHALL cover: rw_flag_i=4'b0011, then a port 0 write with mask 0 -> the first causes no RAM activity and busy_o stays 0; the second gives done_o[0] in cycle 1 with no ram_we_o.
